usb_fs_rx: RTL

Full-speed USB receive front end sitting behind the D+/D- bidirectional pad cells: it takes the pads' input-side signals and turns the line into a byte stream for the packet layer. It covers:
- synchronising and decoding line state;
- recovering bit timing from transitions at OVERSAMPLE clocks per bit;
- NRZI decoding, bit unstuffing, SYNC detection and EOP detection;
- presenting bytes with UTMI-style active/valid/error strobes.

It is the receive counterpart of the pad output path and the packet transmitter.

---
 rtl/usb_fs_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_fs_rx.sv
// Full-speed USB receive front end: synchroniser, DPLL, NRZI decode, unstuffing,
// SYNC/EOP framing, UTMI-style strobes. Optional glitch filter: USB_FS_RX_GLITCH_FILTER_EN.
module usb_fs_rx #(
  parameter int OVERSAMPLE  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_i,
  input  logic       dm_i,
  input  logic       tx_oe,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_error
);
  localparam int PW = $clog2(OVERSAMPLE + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_EOP   = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [SYNC_STAGES-1:0] dp_sync, dm_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync <= '1;
      dm_sync <= '0;
    end else begin
      dp_sync <= {dp_sync[SYNC_STAGES-2:0], dp_i};
      dm_sync <= {dm_sync[SYNC_STAGES-2:0], dm_i};
    end
  end

`ifdef USB_FS_RX_GLITCH_FILTER_EN
  logic [1:0] raw, h1, h2, filt;
  assign raw = {dp_sync[SYNC_STAGES-1], dm_sync[SYNC_STAGES-1]};

  // 2-of-3 vote per wire over the last three synchronised samples
  always_ff @(posedge clk) begin
    if (rst) begin
      h1   <= 2'b10;
      h2   <= 2'b10;
      filt <= 2'b10;
    end else begin
      h1   <= raw;
      h2   <= h1;
      filt <= (raw & h1) | (raw & h2) | (h1 & h2);
    end
  end
  assign line_state = filt;
`else
  assign line_state = {dp_sync[SYNC_STAGES-1], dm_sync[SYNC_STAGES-1]};
`endif

  // DPLL: the cycle a change is seen counts as phase 0, so the strobe lands mid-bit
  logic [1:0]    ls_q;
  logic [PW-1:0] phase_q, phase;
  logic          change, strobe;

  assign change = line_state != ls_q;
  assign phase  = change ? '0 : phase_q;
  assign strobe = phase == PW'(OVERSAMPLE / 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_q    <= 2'b10;
      phase_q <= '0;
    end else begin
      ls_q    <= line_state;
      phase_q <= (phase == PW'(OVERSAMPLE - 1)) ? '0 : phase + PW'(1);
    end
  end

  logic [PW-1:0] hold;
  logic          rx_en;
  assign rx_en = !tx_oe && (hold == '0);

  always_ff @(posedge clk) begin
    if (rst)              hold <= '0;
    else if (tx_oe)       hold <= PW'(OVERSAMPLE);
    else if (hold != '0)  hold <= hold - PW'(1);
  end

  logic is_j, is_k, is_se0, is_se1, bit_d;
  assign is_j   = line_state == 2'b10;
  assign is_k   = line_state == 2'b01;
  assign is_se0 = line_state == 2'b00;
  assign is_se1 = line_state == 2'b11;

  logic [2:0] state;
  logic       prev_dp;
  logic [1:0] zcnt;
  logic [2:0] ones;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic       pend;
  logic       misalign;
  logic       se0_seen;

  assign bit_d = line_state[1] == prev_dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      prev_dp  <= 1'b1;
      zcnt     <= '0;
      ones     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      pend     <= 1'b0;
      misalign <= 1'b0;
      se0_seen <= 1'b0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (!rx_en) begin
        state   <= S_IDLE;
        prev_dp <= 1'b1;
        pend    <= 1'b0;
        ones    <= '0;
      end else if (strobe) begin
        if (is_k)                prev_dp <= 1'b0;
        else if (is_j || is_se0) prev_dp <= 1'b1;
        case (state)
          S_IDLE: begin
            if (is_k) begin
              state <= S_SYNC;
              zcnt  <= 2'd1;
              ones  <= '0;
            end
          end
          S_SYNC: begin
            if (!(is_j || is_k)) begin
              state <= S_IDLE;
            end else if (bit_d) begin
              if (zcnt == 2'd3) begin
                state  <= S_DATA;
                ones   <= 3'd1;
                bitcnt <= '0;
                pend   <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else if (zcnt != 2'd3) begin
              zcnt <= zcnt + 2'd1;
            end
          end
          S_DATA: begin
            if (is_se0) begin
              state    <= S_EOP;
              misalign <= bitcnt != 3'd0;
              if (pend) begin
                rx_valid <= 1'b1;
                rx_data  <= shreg;
                pend     <= 1'b0;
              end
            end else if (is_se1 || (ones == 3'd6 && bit_d)) begin
              rx_error <= 1'b1;
              state    <= S_ABORT;
              se0_seen <= 1'b0;
              pend     <= 1'b0;
            end else if (ones == 3'd6) begin
              // stuffed zero: drop it and release a byte held back for it
              ones <= '0;
              if (pend) begin
                rx_valid <= 1'b1;
                rx_data  <= shreg;
                pend     <= 1'b0;
              end
            end else begin
              shreg  <= {bit_d, shreg[7:1]};
              ones   <= bit_d ? ones + 3'd1 : 3'd0;
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                // a byte ending on the sixth 1 waits for its stuff bit
                if (bit_d && ones == 3'd5) begin
                  pend <= 1'b1;
                end else begin
                  rx_valid <= 1'b1;
                  rx_data  <= {bit_d, shreg[7:1]};
                end
              end
            end
          end
          S_EOP: begin
            if (is_j) begin
              state    <= S_IDLE;
              rx_error <= misalign;
            end
          end
          S_ABORT: begin
            if (is_se0)                state    <= S_ABORT;
            if (is_se0)                se0_seen <= 1'b1;
            else if (is_j && se0_seen) state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_active = (state == S_DATA) || (state == S_EOP);

endmodule
